// File: rtl/switch_pkg.sv
// Shared definitions for the switch egress path: arbiter state encoding,
// default word width and a width helper.
package switch_pkg;

    localparam int unsigned DEF_W_WIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_e;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/switch_rr_pick.sv
// Round-robin requester pick: rotate req so ptr sits at bit 0, find the first
// set bit, then add ptr back modulo N_PORTS.
module switch_rr_pick
    import switch_pkg::*;
#(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned PTR_W   = clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [N_PORTS-1:0] pick,
    output logic [PTR_W-1:0]   pick_idx
);

    localparam logic [PTR_W:0]     N_WRAP = N_PORTS[PTR_W:0];
    localparam logic [N_PORTS-1:0] ONE    = 1;

    logic [N_PORTS-1:0] rotated;
    logic [PTR_W-1:0]   rot_idx;
    logic [PTR_W:0]     sum;
    logic               found;

    assign rotated = (req >> ptr) | (req << (N_PORTS - 32'(ptr)));

    always_comb begin
        found   = 1'b0;
        rot_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!found && rotated[i]) begin
                found   = 1'b1;
                rot_idx = PTR_W'(i);
            end
        end
        sum = {1'b0, rot_idx} + {1'b0, ptr};
        if (sum >= N_WRAP) sum = sum - N_WRAP;
        pick_idx = sum[PTR_W-1:0];
        pick     = found ? (ONE << pick_idx) : '0;
    end

endmodule

// File: rtl/switch_out_arbiter.sv
// Packet-granular round-robin arbiter sharing one egress bus between the
// per-port FWFT FIFOs, with a one-cycle inter-packet gap and stall timeout.
module switch_out_arbiter
    import switch_pkg::*;
#(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
    parameter int unsigned STALL_MAX = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [N_PORTS-1:0]           req,
    input  logic [N_PORTS*W_WIDTH-1:0]   data_in,
    input  logic [N_PORTS-1:0]           eop_in,
    output logic [N_PORTS-1:0]           rd_en,
    output logic [N_PORTS-1:0]           gnt,
    output logic [W_WIDTH-1:0]           out_data,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         abort,
    output logic                         busy
);

    localparam int unsigned        PTR_W      = clog2(N_PORTS);
    localparam int unsigned        CNT_W      = clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0]   STALL_LAST = (STALL_MAX == 0) ? '0 : CNT_W'(STALL_MAX - 1);
    localparam logic [PTR_W-1:0]   LAST_PORT  = PTR_W'(N_PORTS - 1);

    arb_state_e         state_q, state_d;
    logic [N_PORTS-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               abort_q, abort_d;

    logic [N_PORTS-1:0] pick;
    logic [PTR_W-1:0]   pick_idx;
    logic [W_WIDTH-1:0] mux_data;
    logic               mux_eop;
    logic               in_xfer;

    switch_rr_pick #(
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // gnt_q is one-hot or zero, so an OR-mux is enough.
    always_comb begin
        mux_data = '0;
        mux_eop  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gnt_q[i]) begin
                mux_data = mux_data | data_in[i*W_WIDTH +: W_WIDTH];
                mux_eop  = mux_eop | eop_in[i];
            end
        end
    end

    assign in_xfer   = (state_q == ARB_XFER);
    assign out_valid = in_xfer;
    assign out_data  = mux_data;
    assign out_last  = in_xfer & mux_eop;
    // Gated by rst_n so a reset edge mid-packet never pops the FIFO.
    assign rd_en     = (in_xfer && out_ready && rst_n) ? gnt_q : '0;
    assign gnt       = gnt_q;
    assign abort     = abort_q;
    assign busy      = (state_q != ARB_IDLE);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        abort_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (en && (|req)) begin
                    state_d = ARB_XFER;
                    gnt_d   = pick;
                    ptr_d   = (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
                end
            end
            ARB_XFER: begin
                if (out_ready) begin
                    stall_d = '0;
                    if (mux_eop) begin
                        state_d = ARB_GAP;
                        gnt_d   = '0;
                    end
                end else if (STALL_MAX != 0 && stall_q == STALL_LAST) begin
                    state_d = ARB_GAP;
                    gnt_d   = '0;
                    stall_d = '0;
                    abort_d = 1'b1;
                end else if (stall_q != '1) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            ARB_GAP: begin
                state_d = ARB_IDLE;
                stall_d = '0;
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                stall_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Directed bench for switch_out_arbiter: FWFT port FIFOs are modelled in the
// bench, and each scenario checks a snapshot of all outputs per cycle.
module tb_switch_out_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        out_ready = 1'b1;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  eop_in;
    logic [3:0]  rd_en;
    logic [3:0]  gnt;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        abort;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // Port FIFO model: {eop, data} words, head advanced by rd_en.
    logic [8:0] mem [4][8];
    logic [3:0] head [4];
    logic [3:0] cnt [4];
    logic       fifo_clr = 1'b0;

    // Snapshot: gnt, out_valid, out_last, rd_en, out_data, busy, abort.
    logic [19:0] snap;
    assign snap = {gnt, out_valid, out_last, rd_en, out_data, busy, abort};

    switch_out_arbiter #(
        .N_PORTS   (4),
        .W_WIDTH   (8),
        .STALL_MAX (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .data_in   (data_in),
        .eop_in    (eop_in),
        .rd_en     (rd_en),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .abort     (abort),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_clr) head[i] <= 4'd0;
            else if (rd_en[i] && head[i] < cnt[i]) head[i] <= head[i] + 4'd1;
        end
    end

    always_comb begin
        req     = '0;
        data_in = '0;
        eop_in  = '0;
        for (int i = 0; i < 4; i++) begin
            req[i]           = (head[i] < cnt[i]);
            data_in[i*8 +: 8] = mem[i][head[i][2:0]][7:0];
            eop_in[i]        = mem[i][head[i][2:0]][8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int p, input logic [7:0] d, input logic e);
        mem[p][cnt[p][2:0]] = {e, d};
        cnt[p] = cnt[p] + 4'd1;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < 4; i++) cnt[i] = 4'd0;
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_fifos();
        tick();
        vectors++;
        if (snap !== 20'h0) begin
            miscompares++;
            $display("FAIL reset got %h want %h", snap, 20'h0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_packet();
        logic [7:0]  w [3];
        logic [19:0] exp;
        w = '{8'hA1, 8'hA2, 8'hA3};
        load(2, w[0], 1'b0);
        load(2, w[1], 1'b0);
        load(2, w[2], 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            exp = {4'b0100, 1'b1, (k == 2), 4'b0100, w[k], 1'b1, 1'b0};
            vectors++;
            if (snap !== exp) begin
                miscompares++;
                $display("FAIL single_w%0d got %h want %h", k, snap, exp);
            end
        end
        tick();
        vectors++;
        if (snap !== 20'h2) begin
            miscompares++;
            $display("FAIL single_gap got %h want %h", snap, 20'h2);
        end
        tick();
        vectors++;
        if (snap !== 20'h0) begin
            miscompares++;
            $display("FAIL single_idle got %h want %h", snap, 20'h0);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  g [5];
        logic [7:0]  d [5];
        logic [19:0] exp;
        g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        d = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01};
        clear_fifos();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 2; j++) load(p, 8'(16 * p + j), 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            exp = {g[k], 1'b1, 1'b1, g[k], d[k], 1'b1, 1'b0};
            vectors++;
            if (snap !== exp) begin
                miscompares++;
                $display("FAIL rr_xfer%0d got %h want %h", k, snap, exp);
            end
            tick();
            vectors++;
            if (snap !== 20'h2) begin
                miscompares++;
                $display("FAIL rr_gap%0d got %h want %h", k, snap, 20'h2);
            end
            tick();
            vectors++;
            if (snap !== 20'h0) begin
                miscompares++;
                $display("FAIL rr_idle%0d got %h want %h", k, snap, 20'h0);
            end
        end
    endtask

    task automatic test_short_stall();
        logic [19:0] exp [7];
        clear_fifos();
        for (int k = 0; k < 4; k++) load(1, 8'hB0 + 8'(k), (k == 3));
        exp = '{{4'b0010, 1'b1, 1'b0, 4'b0010, 8'hB0, 1'b1, 1'b0},
                {4'b0010, 1'b1, 1'b0, 4'b0000, 8'hB1, 1'b1, 1'b0},
                {4'b0010, 1'b1, 1'b0, 4'b0000, 8'hB1, 1'b1, 1'b0},
                {4'b0010, 1'b1, 1'b0, 4'b0010, 8'hB1, 1'b1, 1'b0},
                {4'b0010, 1'b1, 1'b0, 4'b0010, 8'hB2, 1'b1, 1'b0},
                {4'b0010, 1'b1, 1'b1, 4'b0010, 8'hB3, 1'b1, 1'b0},
                20'h2};
        for (int k = 0; k < 7; k++) begin
            if (k == 1) begin
                tick();
                out_ready = 1'b0;
                #1;
            end else if (k == 3) begin
                out_ready = 1'b1;
                #1;
            end else begin
                tick();
            end
            vectors++;
            if (snap !== exp[k]) begin
                miscompares++;
                $display("FAIL stall_c%0d got %h want %h", k, snap, exp[k]);
            end
        end
        tick();
    endtask

    task automatic test_timeout_abort();
        logic [19:0] exp;
        clear_fifos();
        out_ready = 1'b0;
        load(1, 8'hC0, 1'b0);
        load(1, 8'hC1, 1'b1);
        exp = {4'b0010, 1'b1, 1'b0, 4'b0000, 8'hC0, 1'b1, 1'b0};
        tick();
        load(0, 8'hD0, 1'b1);
        for (int s = 1; s <= 8; s++) begin
            if (s > 1) tick();
            vectors++;
            if (snap !== exp) begin
                miscompares++;
                $display("FAIL abort_stall%0d got %h want %h", s, snap, exp);
            end
        end
        tick();
        vectors++;
        if (snap !== 20'h3) begin
            miscompares++;
            $display("FAIL abort_pulse got %h want %h", snap, 20'h3);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (snap !== 20'h0) begin
            miscompares++;
            $display("FAIL abort_idle got %h want %h", snap, 20'h0);
        end
        tick();
        exp = {4'b0001, 1'b1, 1'b1, 4'b0001, 8'hD0, 1'b1, 1'b0};
        vectors++;
        if (snap !== exp) begin
            miscompares++;
            $display("FAIL abort_next got %h want %h", snap, exp);
        end
        tick();
        clear_fifos();
    endtask

    task automatic test_enable_drop();
        logic [19:0] exp;
        clear_fifos();
        load(1, 8'hE0, 1'b0);
        load(1, 8'hE1, 1'b0);
        load(1, 8'hE2, 1'b1);
        load(3, 8'hF0, 1'b1);
        tick();
        tick();
        en = 1'b0;
        #1;
        exp = {4'b0010, 1'b1, 1'b0, 4'b0010, 8'hE1, 1'b1, 1'b0};
        vectors++;
        if (snap !== exp) begin
            miscompares++;
            $display("FAIL en_w1 got %h want %h", snap, exp);
        end
        tick();
        exp = {4'b0010, 1'b1, 1'b1, 4'b0010, 8'hE2, 1'b1, 1'b0};
        vectors++;
        if (snap !== exp) begin
            miscompares++;
            $display("FAIL en_w2 got %h want %h", snap, exp);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (snap !== 20'h0) begin
                miscompares++;
                $display("FAIL en_hold%0d got %h want %h", k, snap, 20'h0);
            end
        end
        en = 1'b1;
        tick();
        exp = {4'b1000, 1'b1, 1'b1, 4'b1000, 8'hF0, 1'b1, 1'b0};
        vectors++;
        if (snap !== exp) begin
            miscompares++;
            $display("FAIL en_regrant got %h want %h", snap, exp);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_packet();
        logic [19:0] exp;
        clear_fifos();
        load(2, 8'hA0, 1'b0);
        load(2, 8'hA7, 1'b0);
        load(2, 8'hAF, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (snap !== 20'h0) begin
            miscompares++;
            $display("FAIL midrst_out got %h want %h", snap, 20'h0);
        end
        load(0, 8'h5A, 1'b1);
        load(3, 8'h3C, 1'b1);
        rst_n = 1'b1;
        tick();
        exp = {4'b0001, 1'b1, 1'b1, 4'b0001, 8'h5A, 1'b1, 1'b0};
        vectors++;
        if (snap !== exp) begin
            miscompares++;
            $display("FAIL midrst_restart got %h want %h", snap, exp);
        end
        tick();
        tick();
        tick();
        // Port 2 resumes at its second word: the reset edge popped nothing.
        exp = {4'b0100, 1'b1, 1'b0, 4'b0100, 8'hA7, 1'b1, 1'b0};
        vectors++;
        if (snap !== exp) begin
            miscompares++;
            $display("FAIL midrst_nopop got %h want %h", snap, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 4'd0;
            for (int j = 0; j < 8; j++) mem[i][j] = 9'h0;
        end
        test_reset();
        test_single_packet();
        test_round_robin();
        test_short_stall();
        test_timeout_abort();
        test_enable_drop();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
